// File: rtl/hilo_mult_ctrl.sv
// HI/LO multiply issue/writeback controller: feeds an external pipelined unsigned
// multiplier with operand magnitudes, waits out its latency, then sign-corrects into HI/LO.
module hilo_mult_ctrl #(
  parameter int unsigned MUL_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [2:0]  op_code,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [63:0] mul_r,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_WB   = 2'd2;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_MTHI  = 3'd2;
  localparam logic [2:0] OP_MTLO  = 3'd3;

  localparam logic [1:0] CNT_LAST = 2'(MUL_LATENCY - 1);

  logic [1:0]  state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        neg_q, neg_d;
  logic [31:0] mul_a_q, mul_a_d;
  logic [31:0] mul_b_q, mul_b_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        accept;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [63:0] prod_fix;

  assign op_ready = reset_n && (state_q == S_IDLE);
  assign accept   = op_valid && op_ready;
  assign busy     = (state_q != S_IDLE);

  // 0x80000000 negates to itself, which is the correct unsigned magnitude.
  assign abs_a    = op_a[31] ? (~op_a + 32'd1) : op_a;
  assign abs_b    = op_b[31] ? (~op_b + 32'd1) : op_b;
  assign prod_fix = neg_q ? (~mul_r + 64'd1) : mul_r;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    mul_a_d = mul_a_q;
    mul_b_d = mul_b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (op_code)
            OP_MULT: begin
              mul_a_d = abs_a;
              mul_b_d = abs_b;
              neg_d   = op_a[31] ^ op_b[31];
              cnt_d   = 2'd0;
              state_d = S_WAIT;
            end
            OP_MULTU: begin
              mul_a_d = op_a;
              mul_b_d = op_b;
              neg_d   = 1'b0;
              cnt_d   = 2'd0;
              state_d = S_WAIT;
            end
            OP_MTHI: hi_d = op_a;
            OP_MTLO: lo_d = op_a;
            default: ;
          endcase
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == CNT_LAST) begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        hi_d    = prod_fix[63:32];
        lo_d    = prod_fix[31:0];
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 2'd0;
      neg_q   <= 1'b0;
      mul_a_q <= 32'd0;
      mul_b_q <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign mul_a = mul_a_q;
  assign mul_b = mul_b_q;
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule

// File: doc/hilo_mult_ctrl.md
# hilo_mult_ctrl

- Issue and writeback controller for the HI/LO multiply path of the CPU datapath.
- Accepts MULT/MULTU/MTHI/MTLO operations from the execute stage.
- Upstream of the external pipelined unsigned multiplier: converts signed operands to magnitudes, drives the multiplier inputs and tracks its fixed latency. It then sign-corrects the 64-bit product and writes the HI/LO architectural registers.
- Stalls the issuer through a valid/ready handshake while a multiply is in flight.

## Interface

Parameters:
- MUL_LATENCY, 2, number of rising edges from multiplier input sample to valid `mul_r`; legal range 1–4.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset_n  input  1  synchronous reset, active-low; one clock, synchronous active-low reset.
- op_valid  input  1  issuer presents an operation.
- op_ready  output  1  block can accept; transfer occurs on an edge where op_valid && op_ready.
- op_code  input  3  0=MULT (signed), 1=MULTU, 2=MTHI, 3=MTLO, 4–7 reserved.
- op_a  input  32  multiplicand, or source value for MTHI/MTLO.
- op_b  input  32  multiplier operand; ignored for MTHI/MTLO.
- mul_a  output  32  unsigned operand to the multiplier; registered.
- mul_b  output  32  unsigned operand to the multiplier; registered.
- mul_r  input  64  unsigned product from the multiplier.
- busy  output  1  multiply in flight; equals (state != IDLE).
- hi  output  32  HI register.
- lo  output  32  LO register.

## Operation

- States: IDLE, WAIT, WB. A 2-bit counter `cnt` is used in WAIT.
- op_ready = reset_n && (state == IDLE). It is low throughout WAIT and WB.
- IDLE, accept of MULTU:
  - mul_a <= op_a; mul_b <= op_b; neg <= 0; cnt <= 0.
  - Go to WAIT.
- IDLE, accept of MULT:
  - mul_a <= |op_a|; mul_b <= |op_b|, computed in two's complement. |0x80000000| = 0x80000000, which is legal as unsigned.
  - neg <= op_a[31] ^ op_b[31]; cnt <= 0.
  - Go to WAIT.
- IDLE, accept of MTHI: hi <= op_a. MTLO: lo <= op_a. State stays IDLE. These take effect in a single cycle.
- IDLE, accept of reserved code: the handshake completes; no state, HI or LO change.
- WAIT: cnt increments each edge. When cnt == MUL_LATENCY-1, go to WB.
- WB:
  - {hi, lo} <= neg ? (~mul_r + 1) : mul_r. Negation is full 64-bit two's complement.
  - Go to IDLE.
- mul_a and mul_b hold their value outside accept edges. They are not cleared after WB.
- Operand values other than those of an accepted MULT/MULTU never reach mul_a/mul_b.

## Timing

- Accept of a multiply on edge E0:
  - mul_a/mul_b are valid after E0.
  - State is WAIT from E0 to E0+MUL_LATENCY, and WB for the following cycle.
  - hi/lo are updated on edge E0+MUL_LATENCY+1. With the default this is E0+3.
- busy is high for MUL_LATENCY+1 cycles per multiply.
- Next accept is possible on edge E0+MUL_LATENCY+2. Peak multiply throughput is 1 per MUL_LATENCY+2 cycles.
- MTHI/MTLO accepted on edge E: hi/lo show the new value after E. Back-to-back MTHI/MTLO are accepted every cycle.
- An operation presented while busy is held by the issuer, since op_ready is low. The issuer must keep op_valid and its operands stable until the transfer.
- Reset (reset_n low at an edge):
  - hi=0, lo=0, mul_a=0, mul_b=0, neg=0, cnt=0, state=IDLE.
  - busy=0. op_ready=0 while reset_n is low.
- Reset during WAIT/WB aborts the multiply: the in-flight product is discarded and HI/LO are not written.
- The multiplier's own pipeline contents after reset are don't-care. They are never consumed, because WB is only reached through a fresh accept.

## Test plan

- MULTU 0xFFFFFFFF × 0xFFFFFFFF accepted at E0:
  - busy=1 for 3 cycles.
  - At E0+3: hi=0xFFFFFFFE, lo=0x00000001.
  - op_ready returns high after E0+3.
- MULT −3 (0xFFFFFFFD) × 5:
  - mul_a=3, mul_b=5.
  - hi=0xFFFFFFFF, lo=0xFFFFFFF1 at E0+3.
- MULT 0x80000000 × 0x80000000 gives hi=0x40000000, lo=0x00000000.
- MULT 0x80000000 × 0x00000001 gives hi=0xFFFFFFFF, lo=0x80000000.
- MTHI 0x12345678 presented one cycle after a MULT accept:
  - It stalls, with op_ready low.
  - MULT writes at E0+3; MTHI is accepted at E0+4.
  - Final hi=0x12345678, lo=MULT low word.
  - MTLO 0xCAFEF00D on the next cycle gives lo=0xCAFEF00D.
- MULT 7 × 9 accepted, then reset_n low at E0+2:
  - hi=lo=0, busy=0, op_ready=0 during reset.
  - After release, no write of 63 ever occurs.
  - A following MULTU 2 × 3 gives lo=6, hi=0.
